gate_cycle_ctrl: RTL and testbench

Cycle and configuration controller for one egress port's 802.1Qbv gate list executor. It generates the periodic `cycle_start` pulse from a programmable cycle time. It holds a host-written shadow (admin) copy of the 16-entry gate control list and interval list. On commit, at the next cycle boundary, it streams the shadow copy into the executor and then restarts the cycle, so list changes never tear mid-cycle. It sits between the switch's register interface and the list execute state machine in each TSN egress port.

---
 rtl/tsn_gate_pkg.sv | 26 ++
 rtl/gate_cycle_ctrl_if.sv | 39 +++
 rtl/gate_shadow_ram.sv | 34 +++
 rtl/gate_cycle_ctrl.sv | 139 +++++++++++++
 tb/tb_gate_cycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tsn_gate_pkg.sv
// Shared constants, state encoding and helpers for the TSN gate list controller,
// list executor and register block.
package tsn_gate_pkg;
  localparam int NUM_ENTRIES = 16;
  localparam int IDX_W       = 4;
  localparam int CT_W        = 28;
  localparam int GATE_W      = 9;
  localparam int TIME_W      = 20;

  localparam logic [GATE_W-1:0] GATE_DEFAULT = 9'h002;
  localparam logic [TIME_W-1:0] TIME_DEFAULT = 20'h00400;
  localparam logic [CT_W-1:0]   CT_DEFAULT   = 28'h0400000;
  localparam logic [CT_W-1:0]   CT_MIN       = 28'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_START = 2'd3
  } gate_state_e;

  // A cycle shorter than two clks cannot hold a boundary plus a count.
  function automatic logic [CT_W-1:0] clamp_ct(input logic [CT_W-1:0] ct);
    return (ct < CT_MIN) ? CT_MIN : ct;
  endfunction
endpackage

// File: rtl/gate_cycle_ctrl_if.sv
// Register-side configuration and executor-side load/cycle signals of one
// egress port's gate cycle controller.
interface gate_cycle_ctrl_if;
  import tsn_gate_pkg::*;

  logic              gate_enable;
  logic              cfg_gate_wr;
  logic              cfg_time_wr;
  logic [IDX_W-1:0]  cfg_idx;
  logic [GATE_W-1:0] cfg_gate_data;
  logic [TIME_W-1:0] cfg_time_data;
  logic              cfg_ct_wr;
  logic [CT_W-1:0]   cfg_ct_data;
  logic              cfg_commit;
  logic              cfg_busy;
  logic              cfg_drop;
  logic              cycle_start;
  logic              gcl_ld;
  logic [IDX_W-1:0]  gcl_id;
  logic [GATE_W-1:0] gcl_ld_data;
  logic              gcl_time_ld;
  logic [IDX_W-1:0]  gcl_time_id;
  logic [TIME_W-1:0] gcl_ld_time;
  logic [CT_W-1:0]   oper_cycle_time;

  modport master (
    output gate_enable, cfg_gate_wr, cfg_time_wr, cfg_idx, cfg_gate_data,
           cfg_time_data, cfg_ct_wr, cfg_ct_data, cfg_commit,
    input  cfg_busy, cfg_drop, cycle_start, gcl_ld, gcl_id, gcl_ld_data,
           gcl_time_ld, gcl_time_id, gcl_ld_time, oper_cycle_time
  );

  modport slave (
    input  gate_enable, cfg_gate_wr, cfg_time_wr, cfg_idx, cfg_gate_data,
           cfg_time_data, cfg_ct_wr, cfg_ct_data, cfg_commit,
    output cfg_busy, cfg_drop, cycle_start, gcl_ld, gcl_id, gcl_ld_data,
           gcl_time_ld, gcl_time_id, gcl_ld_time, oper_cycle_time
  );
endinterface

// File: rtl/gate_shadow_ram.sv
// Host-written admin copy of the gate and interval lists: one write port,
// one combinational indexed read port.
module gate_shadow_ram
  import tsn_gate_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              gate_we,
  input  logic              time_we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [GATE_W-1:0] gate_wdata,
  input  logic [TIME_W-1:0] time_wdata,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [GATE_W-1:0] gate_rdata,
  output logic [TIME_W-1:0] time_rdata
);
  logic [GATE_W-1:0] gate_mem [NUM_ENTRIES];
  logic [TIME_W-1:0] time_mem [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        gate_mem[i] <= GATE_DEFAULT;
        time_mem[i] <= TIME_DEFAULT;
      end
    end else begin
      if (gate_we) gate_mem[wr_idx] <= gate_wdata;
      if (time_we) time_mem[wr_idx] <= time_wdata;
    end
  end

  assign gate_rdata = gate_mem[rd_idx];
  assign time_rdata = time_mem[rd_idx];
endmodule

// File: rtl/gate_cycle_ctrl.sv
// Cycle timer and commit sequencer: pulses cycle_start each cycle and, on a
// pending commit, streams the shadow lists to the executor at the boundary.
module gate_cycle_ctrl
  import tsn_gate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  gate_cycle_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | gate_enable low, counter held at zero
  // RUN   | counting down to the cycle boundary
  // LOAD  | one shadow entry per clk to the executor
  // START | activation done, cycle_start follows next clk

  gate_state_e       state, state_nxt;
  logic [CT_W-1:0]   remain, remain_d;
  logic [CT_W-1:0]   oper_ct, oper_ct_d;
  logic [CT_W-1:0]   shadow_ct;
  logic [IDX_W-1:0]  ld_idx, ld_idx_d;
  logic              pending, pending_d;
  logic              drop, drop_d;
  logic              cycle_start_d, gcl_ld_d;
  logic              cs_q, ld_q;
  logic [IDX_W-1:0]  id_q;
  logic [GATE_W-1:0] gate_rd, gate_q;
  logic [TIME_W-1:0] time_rd, time_q;
  logic              cfg_any, at_tc, last_idx;

  assign cfg_any  = bus.cfg_gate_wr | bus.cfg_time_wr | bus.cfg_ct_wr | bus.cfg_commit;
  assign at_tc    = (remain == '0);
  assign last_idx = (ld_idx == IDX_W'(NUM_ENTRIES - 1));

  gate_shadow_ram u_shadow (
    .clk        (clk),
    .rst        (rst),
    .gate_we    (bus.cfg_gate_wr & ~pending),
    .time_we    (bus.cfg_time_wr & ~pending),
    .wr_idx     (bus.cfg_idx),
    .gate_wdata (bus.cfg_gate_data),
    .time_wdata (bus.cfg_time_data),
    .rd_idx     (ld_idx_d),
    .gate_rdata (gate_rd),
    .time_rdata (time_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.gate_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = pending ? ST_LOAD : ST_START;
        ST_RUN:   if (at_tc) state_nxt = pending ? ST_LOAD : ST_RUN;
        ST_LOAD:  if (last_idx) state_nxt = ST_START;
        ST_START: state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    remain_d      = '0;
    ld_idx_d      = '0;
    oper_ct_d     = oper_ct;
    pending_d     = pending;
    drop_d        = drop | (pending & cfg_any);
    cycle_start_d = 1'b0;
    gcl_ld_d      = (state_nxt == ST_LOAD);

    // Writes landing with the commit are already in the shadow at LOAD time.
    if (pending) begin
      if (state == ST_START && state_nxt == ST_RUN) pending_d = 1'b0;
    end else if (bus.cfg_commit) begin
      pending_d = 1'b1;
    end

    if (state == ST_LOAD && state_nxt == ST_LOAD) ld_idx_d = ld_idx + 1'b1;

    case (state_nxt)
      ST_RUN: begin
        if (state == ST_START || at_tc) begin
          remain_d      = oper_ct - CT_W'(1);
          cycle_start_d = 1'b1;
        end else begin
          remain_d = remain - CT_W'(1);
        end
      end
      ST_START: if (state == ST_LOAD) oper_ct_d = clamp_ct(shadow_ct);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remain    <= '0;
      ld_idx    <= '0;
      oper_ct   <= CT_DEFAULT;
      shadow_ct <= CT_DEFAULT;
      pending   <= 1'b0;
      drop      <= 1'b0;
      cs_q      <= 1'b0;
      ld_q      <= 1'b0;
      id_q      <= '0;
      gate_q    <= '0;
      time_q    <= '0;
    end else begin
      remain  <= remain_d;
      ld_idx  <= ld_idx_d;
      oper_ct <= oper_ct_d;
      pending <= pending_d;
      drop    <= drop_d;
      cs_q    <= cycle_start_d;
      ld_q    <= gcl_ld_d;
      if (bus.cfg_ct_wr && !pending) shadow_ct <= bus.cfg_ct_data;
      if (gcl_ld_d) begin
        id_q   <= ld_idx_d;
        gate_q <= gate_rd;
        time_q <= time_rd;
      end
    end
  end

  assign bus.cfg_busy        = pending;
  assign bus.cfg_drop        = drop;
  assign bus.cycle_start     = cs_q;
  assign bus.gcl_ld          = ld_q;
  assign bus.gcl_time_ld     = ld_q;
  assign bus.gcl_id          = id_q;
  assign bus.gcl_time_id     = id_q;
  assign bus.gcl_ld_data     = gate_q;
  assign bus.gcl_ld_time     = time_q;
  assign bus.oper_cycle_time = oper_ct;
endmodule

// File: tb/tb_gate_cycle_ctrl.sv
// Bench for gate_cycle_ctrl: directed scenarios plus random configuration
// traffic, every clk compared against a behavioural model of the controller.
module tb_gate_cycle_ctrl;
  import tsn_gate_pkg::*;

  localparam int M_IDLE = 0, M_RUN = 1, M_LOAD = 2, M_START = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_cycle_ctrl_if bus ();

  gate_cycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // model state
  int m_mode, m_cnt, m_k, m_oper, sh_ct;
  bit m_pend, m_drop;
  int sh_gate [NUM_ENTRIES];
  int sh_time [NUM_ENTRIES];
  bit exp_cs, exp_ld;
  int exp_id, exp_gd, exp_td;

  // observation helpers
  int last_cs = -1, prev_cs = -1, ld_count = 0, cap9 = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit pend_old, any;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_k = 0; m_oper = 'h400000; sh_ct = 'h400000;
      m_pend = 0; m_drop = 0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin sh_gate[i] = 'h002; sh_time[i] = 'h400; end
      exp_cs = 0; exp_ld = 0; exp_id = 0; exp_gd = 0; exp_td = 0;
      return;
    end
    pend_old = m_pend;
    any = bus.cfg_gate_wr | bus.cfg_time_wr | bus.cfg_ct_wr | bus.cfg_commit;
    exp_cs = 0;
    exp_ld = 0;
    if (!bus.gate_enable) begin
      m_mode = M_IDLE; m_cnt = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (pend_old) begin m_mode = M_LOAD; m_k = 0; end
          else m_mode = M_START;
        end
        M_RUN: begin
          if (m_cnt == m_oper - 1) begin
            if (pend_old) begin m_mode = M_LOAD; m_k = 0; end
            else begin m_cnt = 0; exp_cs = 1; end
          end else m_cnt++;
        end
        M_LOAD: begin
          if (m_k == NUM_ENTRIES - 1) begin
            m_oper = (sh_ct < 2) ? 2 : sh_ct;
            m_mode = M_START;
          end else m_k++;
        end
        default: begin
          exp_cs = 1; m_cnt = 0; m_pend = 0; m_mode = M_RUN;
        end
      endcase
    end
    if (m_mode == M_LOAD) begin
      exp_ld = 1; exp_id = m_k; exp_gd = sh_gate[m_k]; exp_td = sh_time[m_k];
    end
    if (pend_old) begin
      if (any) m_drop = 1;
    end else begin
      if (bus.cfg_gate_wr) sh_gate[bus.cfg_idx] = int'(bus.cfg_gate_data);
      if (bus.cfg_time_wr) sh_time[bus.cfg_idx] = int'(bus.cfg_time_data);
      if (bus.cfg_ct_wr)   sh_ct = int'(bus.cfg_ct_data);
      if (bus.cfg_commit)  m_pend = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_val("cycle_start", bus.cycle_start, exp_cs);
    check_val("gcl_ld", bus.gcl_ld, exp_ld);
    check_val("gcl_time_ld", bus.gcl_time_ld, exp_ld);
    check_val("cfg_busy", bus.cfg_busy, m_pend);
    check_val("cfg_drop", bus.cfg_drop, m_drop);
    check_val("oper_ct", bus.oper_cycle_time, m_oper);
    if (exp_ld) begin
      check_val("gcl_id", bus.gcl_id, exp_id);
      check_val("gcl_time_id", bus.gcl_time_id, exp_id);
      check_val("gcl_ld_data", bus.gcl_ld_data, exp_gd);
      check_val("gcl_ld_time", bus.gcl_ld_time, exp_td);
    end
    if (bus.cycle_start) begin prev_cs = last_cs; last_cs = cyc; end
    if (bus.gcl_ld) ld_count++;
    if (bus.gcl_ld && bus.gcl_id == 4'd9) cap9 = int'(bus.gcl_ld_data);
  endtask

  task automatic clr_cfg();
    bus.cfg_gate_wr = 0; bus.cfg_time_wr = 0; bus.cfg_ct_wr = 0; bus.cfg_commit = 0;
  endtask

  task automatic wait_cs(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.cycle_start) return;
    end
    check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ld(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.gcl_ld) return;
    end
    check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_load_k(input string tag, input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (m_mode == M_LOAD && m_k == k) return;
    end
    check_val({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int t0, v9, r;
    bus.gate_enable = 0; bus.cfg_idx = 0; bus.cfg_gate_data = 0;
    bus.cfg_time_data = 0; bus.cfg_ct_data = 0;
    clr_cfg();

    rst = 1;
    repeat (3) step();
    rst = 0;
    check_val("rst_gcl_id", bus.gcl_id, 0);
    check_val("rst_gcl_data", bus.gcl_ld_data, 0);
    check_val("rst_oper_ct", bus.oper_cycle_time, 'h400000);
    step();

    // ct = 100 committed while disabled, then enable: 16 default loads, START
    bus.cfg_ct_wr = 1; bus.cfg_ct_data = 28'd100; bus.cfg_commit = 1;
    step();
    clr_cfg();
    step();
    bus.gate_enable = 1;
    ld_count = 0;
    wait_cs("first_start", 40);
    check_val("first_load_count", ld_count, 16);
    wait_cs("period_a", 150);
    check_val("period_100", last_cs - prev_cs, 100);
    wait_cs("period_b", 150);
    check_val("period_100_b", last_cs - prev_cs, 100);

    // mid-cycle edit of entry 5 and commit; a write while busy is dropped
    repeat (30) step();
    bus.cfg_idx = 4'd5; bus.cfg_gate_wr = 1; bus.cfg_gate_data = 9'h180;
    step(); clr_cfg();
    bus.cfg_time_wr = 1; bus.cfg_time_data = 20'h00010;
    step(); clr_cfg();
    bus.cfg_commit = 1;
    step(); clr_cfg();
    bus.cfg_idx = 4'd3; bus.cfg_gate_wr = 1; bus.cfg_gate_data = 9'h0ff;
    step(); clr_cfg();
    check_val("drop_set", bus.cfg_drop, 1);
    t0 = last_cs;
    ld_count = 0;
    wait_ld("reload_a", 120);
    wait_cs("reload_a_start", 40);
    check_val("stretch_117", last_cs - t0, 117);
    check_val("reload_a_count", ld_count, 16);
    repeat (5) step();
    check_val("drop_sticky", bus.cfg_drop, 1);

    // cycle time 0 clamps to 2
    bus.cfg_ct_wr = 1; bus.cfg_ct_data = 28'd0; bus.cfg_commit = 1;
    step(); clr_cfg();
    wait_ld("clamp_ld", 120);
    wait_cs("clamp_start", 40);
    wait_cs("clamp_next", 10);
    check_val("period_2", last_cs - prev_cs, 2);
    check_val("oper_ct_2", bus.oper_cycle_time, 2);
    repeat (7) step();

    // write and commit in the same clk
    v9 = int'($urandom_range(3, 511));
    bus.cfg_idx = 4'd9; bus.cfg_gate_wr = 1; bus.cfg_gate_data = 9'(v9);
    bus.cfg_ct_wr = 1; bus.cfg_ct_data = 28'd50; bus.cfg_commit = 1;
    step(); clr_cfg();
    cap9 = -1;
    wait_ld("samecyc_ld", 10);
    wait_cs("samecyc_start", 40);
    check_val("samecyc_entry9", cap9, v9);
    check_val("oper_ct_50", bus.oper_cycle_time, 50);

    // disable at LOAD k=7, re-enable for a full reload
    bus.cfg_commit = 1;
    step(); clr_cfg();
    wait_load_k("abort_k7", 7, 80);
    bus.gate_enable = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("abort_busy", bus.cfg_busy, 1);
      check_val("abort_no_ld", bus.gcl_ld, 0);
    end
    ld_count = 0;
    bus.gate_enable = 1;
    wait_cs("reenable_start", 40);
    check_val("reenable_count", ld_count, 16);

    // random configuration traffic
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      bus.cfg_idx = 4'($urandom_range(0, 15));
      bus.cfg_gate_data = 9'($urandom_range(0, 511));
      bus.cfg_time_data = 20'($urandom & 32'hfffff);
      bus.cfg_ct_data = 28'($urandom_range(0, 40));
      if (r < 8) bus.cfg_gate_wr = 1;
      else if (r < 14) bus.cfg_time_wr = 1;
      else if (r < 17) bus.cfg_ct_wr = 1;
      if ($urandom_range(0, 29) == 0) bus.cfg_commit = 1;
      if ($urandom_range(0, 249) == 0) bus.gate_enable = ~bus.gate_enable;
      step();
      clr_cfg();
    end

    // reset in the middle of a load
    bus.gate_enable = 1;
    for (int i = 0; i < 300 && m_pend; i++) step();
    check_val("settle_not_busy", bus.cfg_busy, 0);
    bus.cfg_commit = 1;
    step(); clr_cfg();
    wait_load_k("rst_k4", 4, 120);
    rst = 1;
    step();
    rst = 0;
    check_val("rst_mid_busy", bus.cfg_busy, 0);
    check_val("rst_mid_drop", bus.cfg_drop, 0);
    check_val("rst_mid_ld", bus.gcl_ld, 0);
    check_val("rst_mid_oper", bus.oper_cycle_time, 'h400000);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
